// File: rtl/button_conditioner.sv
// Board-pin front end: synchronises switches and buttons, debounces the buttons and
// derives a stretched core reset plus a toggled core-enable level with press strobe.

module button_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk0,
  input  logic rst0,
  input  logic s,
  output logic rise,
  output logic fall,
  output logic high
);
  typedef enum logic [1:0] {IDLE, RISE_CHK, HIGH, FALL_CHK} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rise       = 1'b0;
    fall       = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_next = RISE_CHK;
          cnt_next   = CNT_W'(1);
        end
      end
      RISE_CHK: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          rise       = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_next = FALL_CHK;
          cnt_next   = CNT_W'(1);
        end
      end
      FALL_CHK: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          fall       = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Accepted level after this edge, so a press is visible on its acceptance edge.
  assign high = (state_next == HIGH) || (state_next == FALL_CHK);
endmodule

module button_conditioner #(
  parameter int SW_W      = 16,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20,
  parameter int RST_HOLD  = 16,
  parameter int HOLD_W    = 5
) (
  input  logic            clk0,
  input  logic            rst0,
  input  logic            btn_rst_in,
  input  logic            btn_en_in,
  input  logic [SW_W-1:0] sw_in,
  output logic            proc_rst,
  output logic            proc_en,
  output logic            en_strobe,
  output logic [SW_W-1:0] sw_out
);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

  logic [1:0]        rst_sync, en_sync;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic              rst_rise, rst_fall, rst_high;
  logic              en_rise, en_fall, en_high;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              proc_rst_next;
  logic              unused_en;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rst_sync <= '0;
      en_sync  <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      rst_sync <= {rst_sync[0], btn_rst_in};
      en_sync  <= {en_sync[0], btn_en_in};
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
    end
  end

  assign sw_out = sw_sync;

  button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_rst_db (
    .clk0 (clk0),
    .rst0 (rst0),
    .s    (rst_sync[1]),
    .rise (rst_rise),
    .fall (rst_fall),
    .high (rst_high)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_en_db (
    .clk0 (clk0),
    .rst0 (rst0),
    .s    (en_sync[1]),
    .rise (en_rise),
    .fall (en_fall),
    .high (en_high)
  );

  // Enable release and level carry no meaning for the outputs.
  assign unused_en = en_fall ^ en_high;

  always_comb begin
    hold_next = hold_cnt;
    if (rst_fall)
      hold_next = HOLD_INIT;
    else if (hold_cnt != '0)
      hold_next = hold_cnt - HOLD_W'(1);
    proc_rst_next = rst_high || (rst_rise) || (hold_next != '0);
  end

  // Reset wins over a same-edge enable press, so the enable path keys off proc_rst_next.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      hold_cnt  <= HOLD_INIT;
      proc_rst  <= 1'b1;
      proc_en   <= 1'b0;
      en_strobe <= 1'b0;
    end else begin
      hold_cnt  <= hold_next;
      proc_rst  <= proc_rst_next;
      en_strobe <= en_rise && !proc_rst_next;
      if (proc_rst_next)
        proc_en <= 1'b0;
      else if (en_rise)
        proc_en <= ~proc_en;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized stimulus, all checked
// against a run-length debounce model with delay-line synchronisers and a hold counter.

module tb_button_conditioner;
  localparam int SW_W   = 16;
  localparam int DB     = 4;
  localparam int CNT_W  = 3;
  localparam int RH     = 8;
  localparam int HOLD_W = 4;

  logic            clk0 = 1'b0;
  logic            rst0 = 1'b0;
  logic            btn_rst_in = 1'b0;
  logic            btn_en_in = 1'b0;
  logic [SW_W-1:0] sw_in = '0;
  logic            proc_rst, proc_en, en_strobe;
  logic [SW_W-1:0] sw_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk0 = ~clk0;

  button_conditioner #(
    .SW_W(SW_W), .DB_CYCLES(DB), .CNT_W(CNT_W), .RST_HOLD(RH), .HOLD_W(HOLD_W)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .btn_rst_in (btn_rst_in),
    .btn_en_in  (btn_en_in),
    .sw_in      (sw_in),
    .proc_rst   (proc_rst),
    .proc_en    (proc_en),
    .en_strobe  (en_strobe),
    .sw_out     (sw_out)
  );

  // Reference model: raw inputs reach the qualifier two edges late; a level is accepted
  // once the delayed input has disagreed with it for DB consecutive samples.
  bit              h1_rst, h2_rst, h1_en, h2_en, s_r, s_e;
  bit              lvl_rst, lvl_en, press_r, rel_r, press_e;
  int              run_rst, run_en, hold;
  logic [SW_W-1:0] h_sw;
  logic            exp_rst, exp_en, exp_strobe;
  logic [SW_W-1:0] exp_sw;

  always @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      h1_rst = 0; h2_rst = 0; h1_en = 0; h2_en = 0; h_sw = '0;
      lvl_rst = 0; lvl_en = 0; run_rst = 0; run_en = 0; hold = RH;
      exp_rst = 1'b1; exp_en = 1'b0; exp_strobe = 1'b0; exp_sw = '0;
    end else begin
      s_r = h2_rst; h2_rst = h1_rst; h1_rst = btn_rst_in;
      s_e = h2_en;  h2_en  = h1_en;  h1_en  = btn_en_in;
      exp_sw = h_sw; h_sw = sw_in;

      run_rst = (s_r != lvl_rst) ? run_rst + 1 : 0;
      press_r = 0; rel_r = 0;
      if (run_rst == DB) begin
        lvl_rst = s_r; run_rst = 0; press_r = s_r; rel_r = !s_r;
      end
      run_en = (s_e != lvl_en) ? run_en + 1 : 0;
      press_e = 0;
      if (run_en == DB) begin
        lvl_en = s_e; run_en = 0; press_e = s_e;
      end

      if (rel_r) hold = RH;
      else if (hold > 0) hold = hold - 1;
      exp_rst = lvl_rst || press_r || (hold != 0);

      exp_strobe = press_e && !exp_rst;
      if (exp_rst) exp_en = 1'b0;
      else if (press_e) exp_en = !exp_en;
    end
  end

  function automatic logic [SW_W+2:0] act();
    return {proc_rst, proc_en, en_strobe, sw_out};
  endfunction

  function automatic logic [SW_W+2:0] expv();
    return {exp_rst, exp_en, exp_strobe, exp_sw};
  endfunction

  task automatic test_reset();
    btn_rst_in = 0; btn_en_in = 0; sw_in = '0;
    @(negedge clk0);
    #2 rst0 = 1'b1;
    #1;
    vectors++;
    if (act() !== {1'b1, 1'b0, 1'b0, {SW_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h", act(), {1'b1, 1'b0, 1'b0, {SW_W{1'b0}}});
    end
    repeat (3) @(negedge clk0);
    rst0 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk0);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL reset_model edge %0d: got %h want %h", k, act(), expv());
      end
      vectors++;
      if ({proc_rst, proc_en, sw_out} !== {k < RH, 1'b0, {SW_W{1'b0}}}) begin
        miscompares++;
        $display("FAIL reset_stretch edge %0d: got rst=%b en=%b sw=%h want rst=%b en=0 sw=0",
                 k, proc_rst, proc_en, sw_out, k < RH);
      end
    end
  endtask

  task automatic test_short_press();
    btn_en_in = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk0);
      if (k == 3) btn_en_in = 0;
      vectors++;
      if (act() !== expv() || en_strobe !== 1'b0 || proc_en !== 1'b0) begin
        miscompares++;
        $display("FAIL short_press edge %0d: got %h want %h (no strobe)", k, act(), expv());
      end
    end
  endtask

  task automatic test_enable_toggle();
    for (int p = 0; p < 2; p++) begin
      btn_en_in = 1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk0);
        vectors++;
        if (act() !== expv()) begin
          miscompares++;
          $display("FAIL toggle_model press %0d edge %0d: got %h want %h", p, k, act(), expv());
        end
        vectors++;
        if ({proc_en, en_strobe} !== {(p == 0) ? (k >= 6) : (k < 6), k == 6}) begin
          miscompares++;
          $display("FAIL toggle_timing press %0d edge %0d: got en=%b stb=%b", p, k, proc_en, en_strobe);
        end
      end
      btn_en_in = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk0);
        vectors++;
        if (act() !== expv()) begin
          miscompares++;
          $display("FAIL toggle_release edge %0d: got %h want %h", k, act(), expv());
        end
      end
    end
  endtask

  task automatic test_rst_button();
    btn_en_in = 1;
    repeat (10) @(negedge clk0);
    btn_en_in = 0;
    repeat (10) @(negedge clk0);
    vectors++;
    if (proc_en !== 1'b1 || act() !== expv()) begin
      miscompares++;
      $display("FAIL rst_btn_setup: got en=%b (%h) want en=1 (%h)", proc_en, act(), expv());
    end
    btn_rst_in = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk0);
      vectors++;
      if ({proc_rst, proc_en} !== ((k >= 6) ? 2'b10 : 2'b01) || act() !== expv()) begin
        miscompares++;
        $display("FAIL rst_btn_press edge %0d: got %h want %h", k, act(), expv());
      end
    end
    btn_rst_in = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk0);
      vectors++;
      if ({proc_rst, proc_en} !== {k < 6 + RH, 1'b0} || act() !== expv()) begin
        miscompares++;
        $display("FAIL rst_btn_release edge %0d: got %h want %h", k, act(), expv());
      end
    end
  endtask

  task automatic test_bounce();
    logic start_en;
    int   strobes;
    start_en = exp_en;
    strobes  = 0;
    for (int k = 0; k < 30; k++) begin
      btn_en_in = (k < 20) ? ~k[0] : 1'b1;
      @(negedge clk0);
      if (en_strobe === 1'b1) strobes++;
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL bounce_model edge %0d: got %h want %h", k, act(), expv());
      end
    end
    vectors++;
    if (strobes != 1 || proc_en !== ~start_en) begin
      miscompares++;
      $display("FAIL bounce_once: got %0d strobes en=%b want 1 strobe en=%b", strobes, proc_en, ~start_en);
    end
    btn_en_in = 0;
    repeat (10) @(negedge clk0);
  endtask

  task automatic test_switches_and_collision();
    sw_in = 16'hA5C3;
    @(negedge clk0);
    vectors++;
    if (act() !== expv()) begin
      miscompares++;
      $display("FAIL sw_edge1: got %h want %h", act(), expv());
    end
    @(negedge clk0);
    vectors++;
    if (sw_out !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL sw_edge2: got %h want a5c3", sw_out);
    end
    btn_rst_in = 1; btn_en_in = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk0);
      vectors++;
      if (en_strobe !== 1'b0 || (k >= 6 && {proc_rst, proc_en} !== 2'b10) || act() !== expv()) begin
        miscompares++;
        $display("FAIL collision edge %0d: got %h want %h", k, act(), expv());
      end
    end
    btn_rst_in = 0; btn_en_in = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk0);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL collision_release edge %0d: got %h want %h", k, act(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 5) == 0) btn_rst_in = ~btn_rst_in;
      if ($urandom_range(0, 3) == 0) btn_en_in = ~btn_en_in;
      sw_in = SW_W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst0 = 1'b1;
        #2 rst0 = 1'b0;
      end
      @(negedge clk0);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h want %h", k, act(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_enable_toggle();
    test_rst_button();
    test_bounce();
    test_switches_and_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
